core_muldiv: RTL and testbench
==============================

Name: core_muldiv

Overview:
Iterative RV32M multiply/divide unit attached to the XB stage of the core. It extends the RV32I core to RV32IM without touching the single-cycle ALU.
- Accepts one operation at a time and signals busy so the pipeline stalls.
- Returns one XLEN-bit result with a one-cycle done pulse.
- Parametrised in datapath width and bits retired per cycle.

Parameters:
XLEN, 32, operand/result width in bits (>=8, even).
UNROLL, 1, bits processed per iteration cycle; must divide XLEN (legal 1, 2, 4, 8).

Ports:
clk  input  1  clock, rising-edge.
resetb  input  1  asynchronous active-low reset.
valid_in  input  1  operation request; sampled only in IDLE.
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  input  XLEN  rs1 operand (multiplicand / dividend).
op_b  input  XLEN  rs2 operand (multiplier / divisor).
kill  input  1  synchronous abort from exception/flush logic.
busy  output  1  high whenever state != IDLE; drives pipeline stall.
done  output  1  one-cycle pulse, result valid.
result  output  XLEN  registered result; holds until next done.

Behaviour:
- Reset (resetb low, async): state=IDLE, busy=0, done=0, result=0, counter=0, operand registers=0. Asserting reset mid-operation discards the operation; no done follows.
- States: IDLE -> ITER -> FIX -> DONE -> IDLE.
- IDLE:
  - Edge with valid_in=1 and kill=0: latch funct3 and operand magnitudes plus sign flags; counter=XLEN/UNROLL; go to ITER.
  - Operand sign treatment:
    - MULH/DIV/REM: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - Others: unsigned.
    - MUL: low word is sign-agnostic; treat as unsigned.
- ITER:
  - Each edge processes UNROLL bits and decrements counter.
  - Multiply: shift-add over a 2*XLEN product of magnitudes.
  - Divide: restoring divide, quotient and remainder of magnitudes.
  - Counter reaches 0 on leaving ITER -> FIX.
- FIX (one cycle): apply sign correction and select the result.
  - Product is negated if the operand signs differ.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Register result -> DONE.
- DONE: done=1 for exactly this cycle, busy=1; next edge -> IDLE. valid_in is ignored in DONE.
- Latency: op accepted at edge t; done high during the cycle after edge t+XLEN/UNROLL+1 (t+33 for defaults, t+9 for UNROLL=4). Latency is fixed and independent of operand values (no early-out).
- Divide by zero (fixed latency, no trap):
  - DIV/DIVU -> all ones.
  - REM/REMU -> op_a unchanged.
- Signed overflow: DIV of most-negative by -1 -> most-negative; REM -> 0.
- kill:
  - In any non-IDLE state: next edge -> IDLE, busy=0, done not asserted, result unchanged.
  - kill with valid_in in IDLE: not accepted.
  - kill in the DONE cycle: done still shows this cycle; return to IDLE as normal.
- busy is a pure decode of state (registered source, no combinational path from inputs).
- result changes only on the FIX->DONE edge.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD at edge t -> result 0xFFFFFFEB, done only in the cycle after edge t+33, busy high edges t..t+34.
- MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 7/2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. All at the same latency.
- Start DIV, assert kill for one cycle at iteration 10 -> busy low next cycle, no done pulse, result unchanged. Then a back-to-back valid_in MUL 3*4 is accepted immediately -> 12.
- UNROLL=4 build, random signed/unsigned sweep against a reference model -> all results match, done at t+9. valid_in held high while busy causes no extra acceptances.

Source files
------------

// File: rtl/core_muldiv.sv
// Iterative RV32M multiply/divide unit.
// One operation at a time: shift-add multiply or restoring divide over operand
// magnitudes, UNROLL bits per cycle, then a single sign-fix cycle. Latency is
// fixed at XLEN/UNROLL + 2 cycles from acceptance to the done pulse.
module core_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic            valid_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int ITERS = XLEN / UNROLL;
    localparam int CW    = $clog2(ITERS + 1);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_f3;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    // hi: partial product high word (multiply) or partial remainder (divide).
    // lo: multiplier shifting out (multiply) or dividend/quotient (divide).
    logic [XLEN:0]     hi;
    logic [XLEN-1:0]   lo;

    logic              neg_a_in, neg_b_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic [XLEN:0]     hi_n, sum;
    logic [XLEN-1:0]   lo_n;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   fix_res;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Operand sign flags and magnitudes for the incoming request.
    always_comb begin
        neg_a_in = op_a[XLEN-1] && (funct3 == F_MULH || funct3 == F_MULHSU ||
                                    funct3 == F_DIV  || funct3 == F_REM);
        neg_b_in = op_b[XLEN-1] && (funct3 == F_MULH || funct3 == F_DIV ||
                                    funct3 == F_REM);
        mag_a_in = neg_a_in ? -op_a : op_a;
        mag_b_in = neg_b_in ? -op_b : op_b;
    end

    // One iteration step: UNROLL bits of shift-add or restoring divide.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is
        // inferred; blocking assignments here chain the unrolled bit steps.
        hi_n = hi;
        lo_n = lo;
        sum  = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (op_f3[2]) begin
                hi_n = {hi_n[XLEN-1:0], lo_n[XLEN-1]};
                lo_n = {lo_n[XLEN-2:0], 1'b0};
                if (hi_n >= {1'b0, mag_b}) begin
                    hi_n    = hi_n - {1'b0, mag_b};
                    lo_n[0] = 1'b1;
                end
            end else begin
                sum  = {1'b0, hi_n[XLEN-1:0]} + (lo_n[0] ? {1'b0, mag_a} : '0);
                lo_n = {sum[0], lo_n[XLEN-1:1]};
                hi_n = {1'b0, sum[XLEN:1]};
            end
        end
    end

    // Sign correction and result selection used in the FIX cycle.
    always_comb begin
        prod    = {hi[XLEN-1:0], lo};
        prod_s  = (neg_a ^ neg_b) ? -prod : prod;
        fix_res = '0;
        case (op_f3)
            F_MUL:                      fix_res = prod_s[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
            F_DIV, F_DIVU: begin
                // Divide by zero returns all ones regardless of dividend sign.
                if (mag_b == '0)          fix_res = '1;
                else if (neg_a ^ neg_b)   fix_res = -lo;
                else                      fix_res = lo;
            end
            F_REM, F_REMU:              fix_res = neg_a ? -hi[XLEN-1:0] : hi[XLEN-1:0];
            default:                    fix_res = '0;
        endcase
    end

    // Control FSM with operand, datapath and result registers.
    always_ff @(posedge clk or negedge resetb) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!resetb) begin
            state  <= IDLE;
            cnt    <= '0;
            op_f3  <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in && !kill) begin
                        state <= ITER;
                        cnt   <= ITERS[CW-1:0];
                        op_f3 <= funct3;
                        neg_a <= neg_a_in;
                        neg_b <= neg_b_in;
                        mag_a <= mag_a_in;
                        mag_b <= mag_b_in;
                        hi    <= '0;
                        lo    <= funct3[2] ? mag_a_in : mag_b_in;
                    end
                end
                ITER: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        hi  <= hi_n;
                        lo  <= lo_n;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= FIX;
                    end
                end
                FIX: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        result <= fix_res;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_muldiv.sv
// Scoreboard bench for core_muldiv: a default (UNROLL=1) instance for directed
// cases, kill and reset behaviour, and an UNROLL=4 instance for a random sweep
// with valid_in held high. Expected results come from a plain-arithmetic model.
module tb_core_muldiv;

    localparam int N0 = 32;   // iterations, UNROLL=1
    localparam int N1 = 8;    // iterations, UNROLL=4

    logic        clk = 1'b0;
    logic        resetb;
    logic        valid_in0, kill0, busy0, done0;
    logic        valid_in1, kill1, busy1, done1;
    logic [2:0]  f3_0, f3_1;
    logic [31:0] a0, b0, a1, b1, res0, res1;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        logic [2:0]  f3;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    core_muldiv #(.XLEN(32), .UNROLL(1)) u_dut0 (
        .clk(clk), .resetb(resetb), .valid_in(valid_in0), .funct3(f3_0),
        .op_a(a0), .op_b(b0), .kill(kill0), .busy(busy0), .done(done0),
        .result(res0)
    );

    core_muldiv #(.XLEN(32), .UNROLL(4)) u_dut1 (
        .clk(clk), .resetb(resetb), .valid_in(valid_in1), .funct3(f3_1),
        .op_a(a1), .op_b(b1), .kill(kill1), .busy(busy1), .done(done1),
        .result(res1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RV32M semantics with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = ua * ub; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor, UNROLL=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (resetb && done0) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL u0_spurious_done: done at cycle %0d, expected none", cyc);
            end else begin
                e = q0.pop_front();
                check($sformatf("u0_result_f%0d", e.f3), res0, e.res);
                check("u0_latency", cyc, e.cyc);
            end
        end
    end

    // Monitor, UNROLL=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (resetb && done1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL u1_spurious_done: done at cycle %0d, expected none", cyc);
            end else begin
                e = q1.pop_front();
                check($sformatf("u1_result_f%0d", e.f3), res1, e.res);
                check("u1_latency", cyc, e.cyc);
            end
        end
    end

    // Issue one op to the UNROLL=1 instance and count the busy cycles.
    task automatic run_op0(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res);
        int busy_n;
        @(negedge clk);
        valid_in0 = 1'b1; f3_0 = f; a0 = a; b0 = b;
        q0.push_back('{exp_res, cyc + 1 + N0 + 1, f});
        @(negedge clk);
        valid_in0 = 1'b0; a0 = $urandom; b0 = $urandom;
        busy_n = 0;
        while (busy0 && busy_n < N0 + 10) begin
            busy_n++;
            @(negedge clk);
        end
        check("u0_busy_cycles", busy_n, N0 + 2);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
        check("u0_queue_drained", q0.size(), 0);
        check("u1_queue_drained", q1.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          k;

        resetb = 1'b0;
        valid_in0 = 1'b0; kill0 = 1'b0; f3_0 = '0; a0 = '0; b0 = '0;
        valid_in1 = 1'b0; kill1 = 1'b0; f3_1 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy0", busy0, 0);
        check("reset_done0", done0, 0);
        check("reset_result0", res0, 0);
        check("reset_busy1", busy1, 0);
        check("reset_result1", res1, 0);
        resetb = 1'b1;

        // Directed cases on the default build.
        run_op0(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op0(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op0(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op0(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op0(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_op0(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_op0(3'b111, 32'd7,          32'd2,         32'd1);
        run_op0(3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF);
        run_op0(3'b111, 32'd5,          32'd0,         32'd5);
        run_op0(3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
        run_op0(3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
        run_op0(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op0(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        drain();

        // Kill at iteration 10, then an immediate MUL 3*4.
        @(negedge clk);
        valid_in0 = 1'b1; f3_0 = 3'b100; a0 = 32'd100; b0 = 32'd7;
        @(negedge clk);
        valid_in0 = 1'b0;
        repeat (9) @(negedge clk);
        kill0 = 1'b1;
        @(negedge clk);
        kill0 = 1'b0;
        check("kill_busy_low", busy0, 0);
        check("kill_result_held", res0, 32'h0);
        valid_in0 = 1'b1; f3_0 = 3'b000; a0 = 32'd3; b0 = 32'd4;
        q0.push_back('{32'd12, cyc + 1 + N0 + 1, 3'b000});
        @(negedge clk);
        valid_in0 = 1'b0;
        check("b2b_accepted", busy0, 1);
        drain();

        // kill together with valid_in in IDLE is not accepted.
        @(negedge clk);
        valid_in0 = 1'b1; kill0 = 1'b1; f3_0 = 3'b000;
        @(negedge clk);
        valid_in0 = 1'b0; kill0 = 1'b0;
        check("kill_idle_not_accepted", busy0, 0);

        // kill during DONE: the pulse still shows, then back to IDLE.
        @(negedge clk);
        valid_in0 = 1'b1; f3_0 = 3'b000; a0 = 32'd10; b0 = 32'd20;
        q0.push_back('{32'd200, cyc + 1 + N0 + 1, 3'b000});
        @(negedge clk);
        valid_in0 = 1'b0;
        k = 0;
        while (!done0 && k < N0 + 10) begin
            @(negedge clk);
            k++;
        end
        check("kill_done_seen", done0, 1);
        kill0 = 1'b1;
        @(negedge clk);
        kill0 = 1'b0;
        check("kill_done_idle", busy0, 0);
        check("kill_done_result", res0, 32'd200);

        // Reset in mid-operation discards it.
        @(negedge clk);
        valid_in0 = 1'b1; f3_0 = 3'b101; a0 = 32'd99; b0 = 32'd9;
        @(negedge clk);
        valid_in0 = 1'b0;
        repeat (5) @(negedge clk);
        resetb = 1'b0;
        #1;
        check("midreset_busy", busy0, 0);
        check("midreset_done", done0, 0);
        check("midreset_result", res0, 0);
        @(negedge clk);
        resetb = 1'b1;
        repeat (N0 + 5) @(negedge clk);

        // Random sweep on the UNROLL=4 build, valid_in held high throughout.
        valid_in1 = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (!busy1) begin
                f = 3'($urandom_range(0, 7));
                a = pick();
                b = pick();
                f3_1 = f; a1 = a; b1 = b;
                q1.push_back('{ref_model(f, a, b), cyc + 1 + N1 + 1, f});
            end else begin
                f3_1 = 3'($urandom_range(0, 7)); a1 = $urandom; b1 = $urandom;
            end
            @(negedge clk);
        end
        valid_in1 = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
